dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 24 ++
 rtl/dmem_responder.sv | 113 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-stated data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEPTH_LOG2_DEF  = 8;
  localparam int WAIT_STATES_DEF = 2;
  localparam int CNT_W           = 4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide single-port memory: synchronous write, registered read, no reset.
module dmem_array #(
  parameter int DEPTH_LOG2 = dmem_pkg::DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(2**DEPTH_LOG2)-1];

  // Exactly one port operation per cycle; a write never updates the read register.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: latches a request, waits WAIT_STATES
// cycles, performs one array access and returns a one-cycle ready pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter int WAIT_STATES = WAIT_STATES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable_i,
  input  logic        is_write_mem_i,
  input  logic [31:0] mem_address_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        ready_o,
  output logic        stall_o,
  output logic        misaligned_o
);

  state_t                state;
  logic [CNT_W-1:0]      count;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           wdata_lat;
  logic                  is_write_lat;
  logic                  ready_r;
  logic                  misaligned_r;
  logic                  load_done_r;
  logic                  array_we;
  logic                  array_re;
  logic [31:0]           array_rdata;
  logic                  unused_addr_bits;

  // Upper address bits are dropped on purpose so addresses wrap modulo depth.
  assign unused_addr_bits = ^mem_address_i[31:DEPTH_LOG2+2];

  // Synchronous reset lands in the same edge as the would-be write, so gate it here.
  assign array_we = (state == ST_ACCESS) && is_write_lat && !reset;
  assign array_re = (state == ST_ACCESS) && !is_write_lat && !reset;

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .we    (array_we),
    .re    (array_re),
    .addr  (word_idx),
    .wdata (wdata_lat),
    .rdata (array_rdata)
  );

  // Request FSM with registered completion flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      count        <= '0;
      ready_r      <= 1'b0;
      misaligned_r <= 1'b0;
      load_done_r  <= 1'b0;
    end else begin
      ready_r      <= 1'b0;
      misaligned_r <= 1'b0;
      load_done_r  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_enable_i) begin
            word_idx     <= mem_address_i[DEPTH_LOG2+1:2];
            wdata_lat    <= mem_data_i;
            is_write_lat <= is_write_mem_i;
            if (is_misaligned(mem_address_i)) begin
              state        <= ST_DONE;
              ready_r      <= 1'b1;
              misaligned_r <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state <= ST_ACCESS;
            end else begin
              state <= ST_WAIT;
              count <= CNT_W'(WAIT_STATES);
            end
          end
        end
        ST_WAIT: begin
          if (!mem_enable_i) begin
            state <= ST_IDLE;
            count <= '0;
          end else if (count <= CNT_W'(1)) begin
            state <= ST_ACCESS;
            count <= '0;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        ST_ACCESS: begin
          state       <= ST_DONE;
          ready_r     <= 1'b1;
          load_done_r <= !is_write_lat;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // The array read register is only exposed during the DONE cycle of a load.
  assign mem_data_o   = load_done_r ? array_rdata : 32'd0;
  assign ready_o      = ready_r;
  assign misaligned_o = misaligned_r;
  assign stall_o      = mem_enable_i & ~ready_r;

endmodule
